// File: rtl/vec_player_if.sv
// Signal bundle between a test controller and vec_player: vector-memory write port,
// playback control, the DUT stimulus/response loop and playback status.
interface vec_player_if #(
  parameter int IN_W  = 15,
  parameter int OUT_W = 34,
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
);
   localparam int AW = $clog2(DEPTH);

   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [IN_W-1:0]  wr_stim;
   logic [OUT_W-1:0] wr_exp;
   logic [OUT_W-1:0] wr_mask;
   logic             start;
   logic             abort;
   logic [AW:0]      num_vec;
   logic             loop_en;
   logic [OUT_W-1:0] dut_resp;
   logic [IN_W-1:0]  stim_out;
   logic [AW-1:0]    vec_idx;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] err_count;
   logic             err_flag;
   logic [AW-1:0]    first_err_idx;

   modport master (
      output wr_en, wr_addr, wr_stim, wr_exp, wr_mask,
      output start, abort, num_vec, loop_en, dut_resp,
      input  stim_out, vec_idx, busy, done, err_count, err_flag, first_err_idx
   );

   modport slave (
      input  wr_en, wr_addr, wr_stim, wr_exp, wr_mask,
      input  start, abort, num_vec, loop_en, dut_resp,
      output stim_out, vec_idx, busy, done, err_count, err_flag, first_err_idx
   );
endinterface

// File: rtl/vec_player.sv
// Vector player: drives stored stimulus words to a DUT, holds each for HOLD cycles and
// compares the masked response against the stored expected word on the last hold cycle.
module vec_player #(
  parameter int IN_W  = 15,
  parameter int OUT_W = 34,
  parameter int DEPTH = 16,
  parameter int HOLD  = 1,
  parameter int CNT_W = 8
) (
  input logic        clk,
  input logic        rst_n,
  vec_player_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [AW:0]   DEPTH_V  = (AW+1)'(DEPTH);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [IN_W-1:0]  mem_stim [DEPTH];
   logic [OUT_W-1:0] mem_exp  [DEPTH];
   logic [OUT_W-1:0] mem_mask [DEPTH];

   logic [IN_W-1:0]  stim_q;
   logic [AW-1:0]    vec_idx_q, last_q, first_err_q;
   logic [HW-1:0]    hold_q;
   logic [CNT_W-1:0] err_cnt_q;
   logic             busy_q, done_q, err_flag_q, loop_q;

   logic [AW:0]      n_clamp, n_m1;
   logic [AW-1:0]    next_idx;
   logic             mismatch, hold_last, vec_last;

   // NOTE: the vector memory has no reset; clearing it would turn the array into
   // flops and buys nothing, since unwritten entries are undefined by intent.
   always_ff @(posedge clk) begin
      if (bus.wr_en && !busy_q) begin
         mem_stim[bus.wr_addr] <= bus.wr_stim;
         mem_exp[bus.wr_addr]  <= bus.wr_exp;
         mem_mask[bus.wr_addr] <= bus.wr_mask;
      end
   end

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      n_clamp   = (bus.num_vec > DEPTH_V) ? DEPTH_V : bus.num_vec;
      n_m1      = n_clamp - 1'b1;
      mismatch  = |((bus.dut_resp ^ mem_exp[vec_idx_q]) & mem_mask[vec_idx_q]);
      hold_last = (hold_q == HOLD_MAX);
      vec_last  = (vec_idx_q == last_q);
      next_idx  = vec_last ? '0 : vec_idx_q + 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         stim_q      <= '0;
         vec_idx_q   <= '0;
         last_q      <= '0;
         first_err_q <= '0;
         hold_q      <= '0;
         err_cnt_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_flag_q  <= 1'b0;
         loop_q      <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  err_cnt_q   <= '0;
                  err_flag_q  <= 1'b0;
                  first_err_q <= '0;
                  loop_q      <= bus.loop_en;
                  last_q      <= n_m1[AW-1:0];
                  hold_q      <= '0;
                  if (n_clamp == '0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state     <= RUN;
                     busy_q    <= 1'b1;
                     done_q    <= 1'b0;
                     vec_idx_q <= '0;
                     stim_q    <= mem_stim[0];
                  end
               end
            end
            RUN: begin
               // The compare of the final hold cycle still counts when abort arrives with it.
               if (hold_last && mismatch) begin
                  if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_q <= err_cnt_q + 1'b1;
                  if (!err_flag_q) first_err_q <= vec_idx_q;
                  err_flag_q <= 1'b1;
               end
               if (bus.abort) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  hold_q <= '0;
               end else if (hold_last) begin
                  hold_q <= '0;
                  if (vec_last && !loop_q) begin
                     state  <= DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     vec_idx_q <= next_idx;
                     stim_q    <= mem_stim[next_idx];
                  end
               end else begin
                  hold_q <= hold_q + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.stim_out      = stim_q;
   assign bus.vec_idx       = vec_idx_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.err_count     = err_cnt_q;
   assign bus.err_flag      = err_flag_q;
   assign bus.first_err_idx = first_err_q;
endmodule

// File: tb/tb_vec_player.sv
// Directed bench for vec_player: one instance with HOLD=1/CNT_W=8, one with HOLD=3/CNT_W=2,
// each looped back through a small combinational DUT model.
module tb_vec_player;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;
   int   busy_cycles;
   logic [14:0] stim_v [16];
   localparam logic [33:0] ONES = '1;

   always #5 clk = ~clk;

   vec_player_if #(.IN_W(15), .OUT_W(34), .DEPTH(16), .CNT_W(8)) ia ();
   vec_player_if #(.IN_W(15), .OUT_W(34), .DEPTH(16), .CNT_W(2)) ib ();

   vec_player #(.IN_W(15), .OUT_W(34), .DEPTH(16), .HOLD(1), .CNT_W(8))
      u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
   vec_player #(.IN_W(15), .OUT_W(34), .DEPTH(16), .HOLD(3), .CNT_W(2))
      u_b (.clk(clk), .rst_n(rst_n), .bus(ib));

   function automatic logic [33:0] model(input logic [14:0] s);
      return {4'hA, s, s ^ 15'h1234};
   endfunction

   assign ia.dut_resp = model(ia.stim_out);
   assign ib.dut_resp = model(ib.stim_out);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load_a(input int idx, input logic [33:0] exp_xor, input logic [33:0] mask);
      @(negedge clk);
      ia.wr_en = 1'b1; ia.wr_addr = 4'(idx); ia.wr_stim = stim_v[idx];
      ia.wr_exp = model(stim_v[idx]) ^ exp_xor; ia.wr_mask = mask;
      @(negedge clk);
      ia.wr_en = 1'b0;
   endtask

   task automatic load_b(input int idx, input logic [33:0] exp_xor);
      @(negedge clk);
      ib.wr_en = 1'b1; ib.wr_addr = 4'(idx); ib.wr_stim = stim_v[idx];
      ib.wr_exp = model(stim_v[idx]) ^ exp_xor; ib.wr_mask = ONES;
      @(negedge clk);
      ib.wr_en = 1'b0;
   endtask

   task automatic start_a(input int n, input logic lp);
      @(negedge clk);
      ia.start = 1'b1; ia.num_vec = 5'(n); ia.loop_en = lp;
      @(negedge clk);
      ia.start = 1'b0; ia.num_vec = 5'd0; ia.loop_en = 1'b0;
   endtask

   // Plays n vectors on instance A, checking index/stimulus on every busy cycle.
   task automatic run_a(input int n, input bit inject, input string tag);
      int c = 0;
      int bad = 0;
      start_a(n, 1'b0);
      while (ia.busy && c < 200) begin
         if (ia.vec_idx !== 4'(c) || ia.stim_out !== stim_v[c % 16]) bad++;
         if (inject && c == 2) begin
            ia.start = 1'b1; ia.num_vec = 5'd10;
            ia.wr_en = 1'b1; ia.wr_addr = 4'd1; ia.wr_stim = stim_v[1];
            ia.wr_exp = ~model(stim_v[1]); ia.wr_mask = ONES;
         end
         @(negedge clk);
         ia.start = 1'b0; ia.num_vec = 5'd0; ia.wr_en = 1'b0;
         c++;
      end
      if (c >= 200) check({tag, "_timeout"}, 1, 0);
      check({tag, "_seq"}, bad, 0);
      busy_cycles = c;
   endtask

   task automatic run_b(input string tag);
      int c = 0;
      int bad = 0;
      @(negedge clk);
      ib.start = 1'b1; ib.num_vec = 5'd10; ib.loop_en = 1'b0;
      @(negedge clk);
      ib.start = 1'b0;
      while (ib.busy && c < 200) begin
         if (ib.vec_idx !== 4'(c / 3) || ib.stim_out !== stim_v[(c / 3) % 16]) bad++;
         @(negedge clk);
         c++;
      end
      if (c >= 200) check({tag, "_timeout"}, 1, 0);
      check({tag, "_seq"}, bad, 0);
      busy_cycles = c;
   endtask

   initial begin
      int c;
      for (int i = 0; i < 16; i++) stim_v[i] = 15'(i * 1111 + 7);
      {ia.wr_en, ia.wr_addr, ia.wr_stim, ia.wr_exp, ia.wr_mask} = '0;
      {ia.start, ia.abort, ia.num_vec, ia.loop_en} = '0;
      {ib.wr_en, ib.wr_addr, ib.wr_stim, ib.wr_exp, ib.wr_mask} = '0;
      {ib.start, ib.abort, ib.num_vec, ib.loop_en} = '0;
      rst_n = 1'b0;
      #3;
      check("rst_busy", ia.busy, 0);
      check("rst_done", ia.done, 0);
      check("rst_stim", ia.stim_out, 0);
      check("rst_idx", ia.vec_idx, 0);
      check("rst_err", {ia.err_count, ia.err_flag, ia.first_err_idx}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) load_a(i, '0, ONES);
      for (int i = 0; i < 10; i++) load_b(i, '0);

      // All ten vectors match
      run_a(10, 1'b0, "all_ok");
      check("all_ok_busy", busy_cycles, 10);
      check("all_ok_done", ia.done, 1);
      check("all_ok_err", ia.err_count, 0);
      check("all_ok_flag", ia.err_flag, 0);
      check("all_ok_hold_last", ia.stim_out, stim_v[9]);

      // Expected words of vectors 3 and 7 corrupted
      load_a(3, 34'h1, ONES);
      load_a(7, 34'h1, ONES);
      run_a(10, 1'b0, "two_bad");
      check("two_bad_err", ia.err_count, 2);
      check("two_bad_flag", ia.err_flag, 1);
      check("two_bad_first", ia.first_err_idx, 3);

      // Differences only under mask=0 bits; start also clears the previous errors
      load_a(3, 34'h1, ~34'h1);
      load_a(7, 34'h2_0000_0000, ~34'h2_0000_0000);
      run_a(10, 1'b0, "masked");
      check("masked_err", ia.err_count, 0);
      check("masked_flag", ia.err_flag, 0);
      check("masked_first", ia.first_err_idx, 0);

      // num_vec above DEPTH clamps to 16
      run_a(20, 1'b0, "clamp");
      check("clamp_busy", busy_cycles, 16);

      // Loop over 4 vectors with vector 2 bad, abort at the end of the third pass
      load_a(2, 34'h1, ONES);
      start_a(4, 1'b1);
      repeat (11) @(negedge clk);
      ia.abort = 1'b1;
      @(negedge clk);
      ia.abort = 1'b0;
      check("loop_err", ia.err_count, 3);
      check("loop_done", ia.done, 0);
      check("loop_busy", ia.busy, 0);
      check("loop_idx", ia.vec_idx, 3);
      check("loop_stim", ia.stim_out, stim_v[3]);

      // num_vec=0 finishes immediately
      start_a(0, 1'b0);
      check("zero_done", ia.done, 1);
      check("zero_busy", ia.busy, 0);
      check("zero_err", ia.err_count, 0);

      // start and wr_en while busy are ignored
      run_a(4, 1'b1, "inject");
      check("inject_busy", busy_cycles, 4);
      check("inject_err", ia.err_count, 1);
      run_a(2, 1'b0, "inject_wr");
      check("inject_wr_err", ia.err_count, 0);

      // Write while DONE takes effect
      load_a(0, 34'h1, ONES);
      run_a(1, 1'b0, "done_wr");
      check("done_wr_err", ia.err_count, 1);
      check("done_wr_flag", ia.err_flag, 1);
      check("done_wr_first", ia.first_err_idx, 0);

      // Asynchronous reset at vector 5, then replay from vector 0
      load_a(0, '0, ONES);
      load_a(2, '0, ONES);
      start_a(10, 1'b0);
      c = 0;
      while (ia.vec_idx != 4'd5 && c < 50) begin
         @(negedge clk);
         c++;
      end
      check("rst_mid_reach5", ia.vec_idx, 5);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_busy", ia.busy, 0);
      check("rst_mid_done", ia.done, 0);
      check("rst_mid_stim", ia.stim_out, 0);
      check("rst_mid_idx", ia.vec_idx, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid_idle_done", ia.done, 0);
      run_a(10, 1'b0, "replay");
      check("replay_busy", busy_cycles, 10);
      check("replay_err", ia.err_count, 0);

      // HOLD=3 instance: each vector stable three cycles
      run_b("hold3");
      check("hold3_busy", busy_cycles, 30);
      check("hold3_err", ib.err_count, 0);
      check("hold3_done", ib.done, 1);

      // CNT_W=2 saturates at 3 with five mismatches
      load_b(1, 34'h4);
      load_b(2, 34'h4);
      load_b(4, 34'h4);
      load_b(6, 34'h4);
      load_b(8, 34'h4);
      run_b("sat");
      check("sat_err", ib.err_count, 3);
      check("sat_flag", ib.err_flag, 1);
      check("sat_first", ib.first_err_idx, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/vec_player.md
VEC_PLAYER -- requirements
Module: vec_player

Interface
REQ-001 Parameter IN_W, default 15, width of stimulus vector driven to the DUT.
REQ-002 Parameter OUT_W, default 34, width of DUT response and expected vector.
REQ-003 Parameter DEPTH, default 16, vector memory entries (power of two, >=2); AW = clog2(DEPTH).
REQ-004 Parameter HOLD, default 1, clock cycles each vector is held (>=1).
REQ-005 Parameter CNT_W, default 8, error counter width.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 wr_en  in  1  write strobe into vector memory.
REQ-009 wr_addr  in  AW  write address.
REQ-010 wr_stim  in  IN_W  stimulus word to store.
REQ-011 wr_exp  in  OUT_W  expected response word to store.
REQ-012 wr_mask  in  OUT_W  compare mask to store (1 = bit checked).
REQ-013 start  in  1  pulse: begin playback.
REQ-014 abort  in  1  pulse: stop playback.
REQ-015 num_vec  in  AW+1  vectors to play (0..DEPTH), sampled with start.
REQ-016 loop_en  in  1  repeat sequence until abort, sampled with start.
REQ-017 dut_resp  in  OUT_W  DUT response, combinational from stim_out.
REQ-018 stim_out  out  IN_W  registered stimulus to the DUT.
REQ-019 vec_idx  out  AW  index of vector currently driven.
REQ-020 busy  out  1  playback in progress.
REQ-021 done  out  1  sticky completion flag.
REQ-022 err_count  out  CNT_W  mismatch count, saturating.
REQ-023 err_flag  out  1  at least one mismatch since start.
REQ-024 first_err_idx  out  AW  index of first mismatching vector.

Function
REQ-025 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-026 IDLE: start with num_vec>0 -> RUN; start with num_vec=0 -> DONE, no vector driven; start also clears done, err_count, err_flag, first_err_idx.
REQ-027 Start sampled at edge t: stim_out = mem[0].stim and vec_idx=0 after edge t+1's preceding edge, i.e. visible in cycle t+1; busy=1 same cycle.
REQ-028 RUN: each vector held exactly HOLD cycles; hold counter 0..HOLD-1.
REQ-029 On last hold cycle, compare ((dut_resp ^ exp) & mask) != 0 -> mismatch for that vector; compare occurs once per vector per pass.
REQ-030 Mismatch: err_count += 1, saturating at 2^CNT_W-1; err_flag set; first_err_idx loaded only on first mismatch since start.
REQ-031 After vector num_vec-1: loop_en=0 -> DONE; loop_en=1 -> wrap to index 0, keep counters accumulating.
REQ-032 DONE: busy=0, done=1, stim_out holds last vector; start -> behaves as from IDLE.
REQ-033 abort in RUN -> IDLE next edge, busy=0, done=0, counters/flags retained, stim_out retained; abort has priority over compare and start same cycle (compare of that cycle still counted).
REQ-034 start or num_vec changes while busy=1 are ignored.
REQ-035 wr_en while busy=1 is ignored; writes while IDLE/DONE take effect next edge.
REQ-036 Write and playback index never collide (REQ-035), so no read-during-write rule needed.
REQ-037 num_vec > DEPTH clamped to DEPTH.
REQ-038 Memory contents are not reset; unwritten entries play as X/undefined.

Reset
REQ-039 rst_n low forces immediately: state IDLE, stim_out=0, vec_idx=0, busy=0, done=0, err_count=0, err_flag=0, first_err_idx=0, hold counter 0.
REQ-040 Reset mid-playback aborts without setting done; first edge after release is IDLE.

Verification
REQ-041 DEPTH=16,HOLD=1: load 10 vectors, DUT model matches all, start num_vec=10 -> busy 10 cycles, done=1, err_count=0, err_flag=0.
REQ-042 Corrupt expected of vector 3 and 7 -> err_count=2, err_flag=1, first_err_idx=3.
REQ-043 Mismatch only in bits with mask=0 -> err_count=0; HOLD=3 -> each vector stable 3 cycles, busy 30 cycles for 10 vectors.
REQ-044 loop_en=1, num_vec=4, one bad vector, abort after 3 passes -> err_count=3, done=0, busy=0; CNT_W=2 with 5 mismatches -> err_count=3.
REQ-045 start with num_vec=0 -> done=1 next cycle, busy never 1; start while busy and wr_en while busy -> no effect.
REQ-046 rst_n low at vector 5 -> all outputs to reset values asynchronously; restart replays from vector 0.
